// File: rtl/spi_slave_4mb.sv
// SPI mode-0 slave front-end for the register bank: decodes 56-bit CMD/ADDR/DATA
// frames into a write strobe or a read request, and shifts read data out on MISO.
module spi_slave_4mb #(
  parameter int          SYNC_STAGES = 2,
  parameter int          READ_LAT    = 2,
  parameter logic [7:0]  CMD_WRITE   = 8'h02,
  parameter logic [7:0]  CMD_READ    = 8'h03
) (
  input  logic        clk_100m,
  input  logic        rst_n_syn,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [15:0] addr,
  output logic [31:0] data_mosi,
  output logic        data_mosi_rdy,
  output logic        rd_req,
  input  logic [31:0] data_miso,
  output logic        frame_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_WAIT_CS} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall;

  state_e        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d, cnt_nxt;
  logic [31:0]   shift_q, shift_d, shift_nxt;
  logic [31:0]   tx_q, tx_d;
  logic [31:0]   data_q, data_d;
  logic [15:0]   addr_q, addr_d;
  logic          rd_frame_q, rd_frame_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_req_q;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;
  logic          oe_q, oe_d;
  logic [READ_LAT-1:0] rd_pipe_q;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_frame_d = rd_frame_q;
    rd_pend_d  = 1'b0;
    rdy_d      = 1'b0;
    err_d      = 1'b0;
    shift_nxt  = {shift_q[30:0], mosi_s};
    cnt_nxt    = cnt_q + 6'd1;
    case (state_q)
      ST_IDLE: if (cs_fall) begin
        state_d    = ST_CMD;
        cnt_d      = '0;
        shift_d    = '0;
        rd_frame_d = 1'b0;
      end
      ST_CMD, ST_ADDR, ST_DATA: begin
        // A rise wins over a simultaneous deselect so a frame ending on bit 56 completes.
        if (sclk_rise) begin
          cnt_d   = cnt_nxt;
          shift_d = shift_nxt;
          if (state_q == ST_CMD && cnt_nxt == 6'd8) begin
            if (shift_nxt[7:0] == CMD_WRITE) begin
              state_d = ST_ADDR;
            end else if (shift_nxt[7:0] == CMD_READ) begin
              state_d    = ST_ADDR;
              rd_frame_d = 1'b1;
            end else begin
              state_d = ST_WAIT_CS;
              err_d   = 1'b1;
            end
          end else if (state_q == ST_ADDR && cnt_nxt == 6'd24) begin
            state_d   = ST_DATA;
            addr_d    = shift_nxt[15:0];
            rd_pend_d = rd_frame_q;
          end else if (state_q == ST_DATA && cnt_nxt == 6'd56) begin
            state_d = ST_WAIT_CS;
            if (!rd_frame_q) begin
              data_d = shift_nxt;
              rdy_d  = 1'b1;
            end
          end
        end else if (cs_s) begin
          state_d = ST_IDLE;
          err_d   = (cnt_q != 6'd0);
        end
      end
      ST_WAIT_CS: if (cs_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The fall right after bit 24 must not shift: TX[31] is the first data bit.
    tx_d = tx_q;
    if (rd_pipe_q[READ_LAT-1])
      tx_d = data_miso;
    else if (sclk_fall && state_q == ST_DATA && cnt_q > 6'd24)
      tx_d = {tx_q[30:0], 1'b0};

    oe_d = (state_d == ST_DATA) && rd_frame_d;
  end

  always_ff @(posedge clk_100m or negedge rst_n_syn) begin
    if (!rst_n_syn) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_frame_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_req_q    <= 1'b0;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
      oe_q        <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rd_frame_q  <= rd_frame_d;
      rd_pend_q   <= rd_pend_d;
      rd_req_q    <= rd_pend_q;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
      oe_q        <= oe_d;
      rd_pipe_q[0] <= rd_req_q;
      for (int i = 1; i < READ_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign spi_miso_oe   = oe_q;
  assign spi_miso      = oe_q & tx_q[31];
  assign addr          = addr_q;
  assign data_mosi     = data_q;
  assign data_mosi_rdy = rdy_q;
  assign rd_req        = rd_req_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_spi_slave_4mb.sv
// Directed frame-level bench for spi_slave_4mb: expected strobes, read requests and
// frame errors are queued per frame and matched against the DUT every cycle.
module tb_spi_slave_4mb;
  localparam int READ_LAT = 2;
  localparam int HALF     = 80;   // 6.25 MHz SCLK half period in ns

  logic        clk_100m = 1'b0;
  logic        rst_n_syn = 1'b0;
  logic        spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] addr;
  logic [31:0] data_mosi;
  logic        data_mosi_rdy, rd_req, frame_err;
  logic [31:0] data_miso = 32'h1234_5678;

  spi_slave_4mb #(.SYNC_STAGES(2), .READ_LAT(READ_LAT), .CMD_WRITE(8'h02), .CMD_READ(8'h03)) dut (
    .clk_100m(clk_100m), .rst_n_syn(rst_n_syn), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .addr(addr),
    .data_mosi(data_mosi), .data_mosi_rdy(data_mosi_rdy), .rd_req(rd_req),
    .data_miso(data_miso), .frame_err(frame_err));

  always #5 clk_100m = ~clk_100m;

  typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  int          exp_err = 0;
  int          checks = 0, errors = 0;
  bit          read_active = 1'b0;
  logic [31:0] rd_val = 32'h0;
  logic [31:0] cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register-mux stand-in: data is only valid on the exact sampling cycle.
  initial forever begin
    @(negedge clk_100m);
    if (rd_req) begin
      repeat (READ_LAT) @(posedge clk_100m);
      #1 data_miso = rd_val;
      @(posedge clk_100m);
      #1 data_miso = 32'h1234_5678;
    end
  end

  always @(negedge clk_100m) begin
    if (data_mosi_rdy) begin
      if (exp_wr.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("strobe_addr", {16'h0, addr}, {16'h0, e.a});
        check("strobe_data", data_mosi, e.d);
      end
    end
    if (rd_req) begin
      if (exp_rd.size() == 0) check("unexpected_rd_req", 32'd1, 32'd0);
      else check("rd_req_addr", {16'h0, addr}, {16'h0, exp_rd.pop_front()});
    end
    if (frame_err) begin
      if (exp_err == 0) check("unexpected_frame_err", 32'd1, 32'd0);
      else exp_err--;
    end
    if (!spi_miso_oe) check("miso_idle", {31'h0, spi_miso}, 32'd0);
    if (!read_active) check("oe_outside_read", {31'h0, spi_miso_oe}, 32'd0);
  end

  task automatic spi_frame(input logic [55:0] f, input int nbits, input bit raise_cs,
                           output logic [31:0] c);
    c = '0;
    spi_cs_n = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = f[55-i];
      #(HALF);
      if (i >= 24) c = {c[30:0], spi_miso};
      if (read_active) check("oe_at_bit", {31'h0, spi_miso_oe}, {31'h0, (i >= 24)});
      spi_sclk = 1'b1;
      #(HALF);
      spi_sclk = 1'b0;
    end
    spi_mosi = 1'b0;
    #(HALF);
    if (raise_cs) spi_cs_n = 1'b1;
    #(4*HALF);
  endtask

  task automatic write_frame(input logic [15:0] a, input logic [31:0] d);
    exp_wr.push_back('{a: a, d: d});
    spi_frame({8'h02, a, d}, 56, 1'b1, cap);
  endtask

  task automatic drain(input string tag);
    #(400);
    check({tag, "_wr_left"}, exp_wr.size(), 0);
    check({tag, "_rd_left"}, exp_rd.size(), 0);
    check({tag, "_err_left"}, exp_err, 0);
  endtask

  initial begin
    #23;
    check("rst_addr", {16'h0, addr}, 32'h0);
    check("rst_data", data_mosi, 32'h0);
    check("rst_strobes", {28'h0, data_mosi_rdy, rd_req, frame_err, spi_miso_oe}, 32'h0);
    #20 rst_n_syn = 1'b1;
    #(4*HALF);

    // Plain write
    write_frame(16'h0010, 32'hDEAD_BEEF);
    drain("wr1");
    check("wr1_addr_lit", {16'h0, addr}, 32'h0000_0010);
    check("wr1_data_lit", data_mosi, 32'hDEAD_BEEF);

    // Read: master must capture exactly the returned word
    read_active = 1'b1;
    rd_val = 32'hA5A5_0F0F;
    exp_rd.push_back(16'h0004);
    spi_frame({8'h03, 16'h0004, 32'h0}, 56, 1'b1, cap);
    read_active = 1'b0;
    check("rd_capture", cap, 32'hA5A5_0F0F);
    drain("rd1");
    check("rd_keeps_wdata", data_mosi, 32'hDEAD_BEEF);

    // Second read with a different pattern
    read_active = 1'b1;
    rd_val = 32'h8000_0001;
    exp_rd.push_back(16'hFFFE);
    spi_frame({8'h03, 16'hFFFE, 32'hFFFF_FFFF}, 56, 1'b1, cap);
    read_active = 1'b0;
    check("rd2_capture", cap, 32'h8000_0001);
    drain("rd2");

    // Bad command: one error, trailing clocks ignored
    exp_err++;
    spi_frame({8'h7E, 16'h0001, 32'hFFFF_FFFF}, 56, 1'b1, cap);
    drain("badcmd");
    check("badcmd_addr_held", {16'h0, addr}, 32'h0000_FFFE);

    // Abort after 40 bits, then a good write
    exp_err++;
    spi_frame({8'h02, 16'h0020, 32'hCAFE_F00D}, 40, 1'b1, cap);
    drain("abort");
    write_frame(16'h0020, 32'h0BAD_F00D);
    drain("after_abort");

    // Select without clocks is not an error
    spi_frame(56'h0, 0, 1'b1, cap);
    drain("empty_sel");

    // Back-to-back writes with 2 SCLK periods of deselect
    write_frame(16'h0100, 32'h1111_2222);
    write_frame(16'h0200, 32'hFFFF_0000);
    drain("b2b");
    check("b2b_data_lit", data_mosi, 32'hFFFF_0000);

    // Reset in the middle of the data phase
    spi_frame({8'h02, 16'h0300, 32'h5555_AAAA}, 30, 1'b0, cap);
    rst_n_syn = 1'b0;
    #1;
    check("midrst_addr", {16'h0, addr}, 32'h0);
    check("midrst_data", data_mosi, 32'h0);
    check("midrst_strobes", {28'h0, data_mosi_rdy, rd_req, frame_err, spi_miso_oe}, 32'h0);
    spi_cs_n = 1'b1;
    #(199);
    rst_n_syn = 1'b1;
    #(4*HALF);
    drain("midrst");
    write_frame(16'h0044, 32'h0123_4567);
    drain("post_rst");
    check("post_rst_data_lit", data_mosi, 32'h0123_4567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(5_000_000);
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/spi_slave_4mb.md
Name: spi_slave_4mb

Overview:
- SPI slave front-end that turns host SPI frames into the register-bank write strobe (addr, data_mosi, data_mosi_rdy).
- Serves read frames by requesting the addressed register value and shifting it out on MISO.
- Sits directly upstream of the register bank. It runs entirely in the clk_100m domain and oversamples the SPI pins.

Parameters:
- SYNC_STAGES, 2, number of flops in the pin synchronizers for spi_sclk, spi_cs_n and spi_mosi (minimum 2).
- READ_LAT, 2, number of clk_100m cycles from the rd_req pulse to data_miso being valid.
- CMD_WRITE, 8'h02, command byte for a register write.
- CMD_READ, 8'h03, command byte for a register read.

Ports:
- clk_100m  in  1  system clock, 100 MHz.
- rst_n_syn  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), 6.25 MHz maximum.
- spi_cs_n  in  1  SPI chip select, active low.
- spi_mosi  in  1  SPI data from the master.
- spi_miso  out  1  SPI data to the master.
- spi_miso_oe  out  1  MISO output enable; 1 only while selected in a read frame.
- addr  out  16  register address of the current frame.
- data_mosi  out  32  write data; valid while data_mosi_rdy=1.
- data_mosi_rdy  out  1  one-cycle write strobe.
- rd_req  out  1  one-cycle read request; addr is valid while rd_req=1.
- data_miso  in  32  read data from the register mux, sampled READ_LAT cycles after rd_req.
- frame_err  out  1  one-cycle pulse on a bad frame.

Behaviour:
- Reset: all outputs are 0, FSM in IDLE, shift registers and bit counter cleared. Reset is asynchronous and is honoured in any state.
- Synchronizers: spi_sclk, spi_cs_n and spi_mosi each pass through SYNC_STAGES flops before use.
  - The spi_cs_n synchronizer resets to 1; the other two reset to 0.
  - Edge detection compares the last two synchronized samples of sclk: rise = 0->1, fall = 1->0.
- Frame format: 56 bits, MSB first.
  - CMD[7:0], then ADDR[15:0], then DATA[31:0].
  - MOSI is sampled on each sclk rise.
  - MISO is updated on each sclk fall.
- Bit counter: 6 bits, counts sampled rises from 0 to 56. It clears on the synchronized cs_n falling edge.
- FSM states: IDLE, CMD, ADDR, DATA, WAIT_CS.
  - IDLE -> CMD on synchronized cs_n 1->0.
  - CMD -> ADDR after the 8th rise. The command is decoded at this point. Any other byte: frame_err pulse, go to WAIT_CS.
  - ADDR -> DATA after the 24th rise. addr is updated from the shift register in the same cycle.
    - For a read, rd_req pulses in the cycle after addr updates.
    - The 32-bit TX shift register loads data_miso exactly READ_LAT cycles after rd_req.
  - DATA -> WAIT_CS after the 56th rise. For a write, data_mosi is loaded and data_mosi_rdy pulses one cycle after that rise detect, together with the already-held addr.
  - WAIT_CS -> IDLE on synchronized cs_n = 1. Extra sclk edges in WAIT_CS are ignored: no strobe, no error.
- Early deassertion: synchronized cs_n rising in CMD, ADDR or DATA (bit count 1..55) means:
  - frame_err pulses for one cycle;
  - no data_mosi_rdy is issued;
  - the FSM returns to IDLE.
  - cs_n rising at bit count 0 (select with no clocks) is not an error.
- cs_n reasserted while in WAIT_CS is not seen until cs_n has been observed high for at least one synchronized sample.
- MISO:
  - spi_miso_oe = 1 in the DATA state of a read frame while cs_n is low; 0 otherwise.
  - spi_miso = TX[31] while oe = 1, else 0. The register shifts left on each fall during DATA.
  - TX[31] must be stable before the 25th rise. This is guaranteed because SYNC_STAGES+1+1+READ_LAT ≤ 8 cycles, which is half of the minimum SCLK period.
- addr holds its last value between frames. data_mosi holds its last write value.
- A read frame never asserts data_mosi_rdy. A write frame never asserts rd_req.
- Simultaneous 56th rise and cs_n deassertion in the same cycle: the rise takes priority, the frame completes and the strobe is issued.

Test Plan:
- Write frame CMD=02, ADDR=0x0010, DATA=0xDEADBEEF at 6.25 MHz -> exactly one data_mosi_rdy pulse with addr=0x0010, data_mosi=0xDEADBEEF; frame_err stays 0.
- Read frame CMD=03, ADDR=0x0004, with the bench returning data_miso=0xA5A5_0F0F READ_LAT cycles after rd_req -> one rd_req with addr=0x0004; the master captures 0xA5A50F0F; spi_miso_oe is high only during the 32 data bits; data_mosi_rdy stays 0.
- Bad command 0x7E followed by 48 more clocks -> one frame_err after the 8th bit; no rd_req, no data_mosi_rdy; MISO stays 0.
- Write frame aborted (cs_n high) after 40 bits -> one frame_err; no data_mosi_rdy; a following complete write to 0x0020 strobes correctly.
- Back-to-back writes with cs_n high for 2 SCLK periods -> two strobes carrying the correct addr/data each.
- Reset asserted mid-DATA of a write -> all outputs 0 immediately; no strobe after release; the next full frame works.
